// File: rtl/seq_alu_pkg.sv
// Shared constants for seq_alu: opcode encoding, branch modes and FSM state encoding.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_MOV = 3'd3;
    localparam logic [2:0] OP_ADC = 3'd4;
    localparam logic [2:0] OP_SBC = 3'd5;
    localparam logic [2:0] OP_BR  = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [1:0] BR_UNC    = 2'd0;
    localparam logic [1:0] BR_CARRY  = 2'd1;
    localparam logic [1:0] BR_BORROW = 2'd2;
    localparam logic [1:0] BR_TOGGLE = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, one multiplier bit per clock.
// Only built when SEQ_ALU_MUL_EN is defined.
`ifdef SEQ_ALU_MUL_EN
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] multiplicand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   multiplier;
    logic [CNT_W-1:0]   count;

    // product already includes the step in flight, so done marks the final iteration
    assign busy    = (count != '0);
    assign done    = (count == CNT_W'(1));
    assign product = acc + (multiplier[0] ? multiplicand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multiplicand <= '0;
            acc          <= '0;
            multiplier   <= '0;
            count        <= '0;
        end else if (start) begin
            multiplicand <= {{WIDTH{1'b0}}, a};
            acc          <= '0;
            multiplier   <= b;
            count        <= CNT_W'(WIDTH);
        end else if (busy) begin
            acc          <= product;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            count        <= count - CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake, sticky flags and a branch unit.
// Define SEQ_ALU_MUL_EN to build the iterative multiplier behind opcode 7.
module seq_alu #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addrs,
    input  logic [WIDTH-1:0]  d_in0,
    input  logic [WIDTH-1:0]  d_in1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  d_out,
    output logic              carry,
    output logic              borrow,
    output logic              zero,
    output logic              bcf,
    output logic              bbf,
    output logic              buc,
    output logic              toggle_out,
    output logic              illegal
);
    import seq_alu_pkg::*;

    logic [1:0]       state;
    logic             started;
    logic             accept;
    logic [1:0]       brMode;
    logic             carryIn;
    logic             borrowIn;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             unusedBits;

    // started keeps in_ready low until the first clock after reset release
    assign in_ready   = started && (state == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == ST_HOLD);
    assign brMode     = addrs[1:0];
    assign unusedBits = ^addrs;

    assign carryIn  = (opcode == OP_ADC) && carry;
    assign borrowIn = (opcode == OP_SBC) && borrow;
    assign sum      = {1'b0, d_in0} + {1'b0, d_in1} + {{WIDTH{1'b0}}, carryIn};
    assign diff     = {1'b0, d_in0} - {1'b0, d_in1} - {{WIDTH{1'b0}}, borrowIn};

`ifdef SEQ_ALU_MUL_EN
    logic                 mulStart;
    logic                 mulDone;
    logic                 unusedMulBusy;
    logic [2*WIDTH-1:0]   mulProduct;

    assign mulStart = accept && (opcode == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) uMul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mulStart),
        .a       (d_in0),
        .b       (d_in1),
        .busy    (unusedMulBusy),
        .done    (mulDone),
        .product (mulProduct)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            d_out      <= '0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
            zero       <= 1'b0;
            bcf        <= 1'b0;
            bbf        <= 1'b0;
            buc        <= 1'b0;
            toggle_out <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_HOLD;
                        bcf     <= 1'b0;
                        bbf     <= 1'b0;
                        buc     <= 1'b0;
                        illegal <= 1'b0;
                        case (opcode)
                            OP_ADD, OP_ADC: begin
                                d_out <= sum[WIDTH-1:0];
                                carry <= sum[WIDTH];
                                zero  <= (sum[WIDTH-1:0] == '0);
                            end
                            OP_SUB, OP_SBC: begin
                                d_out  <= diff[WIDTH-1:0];
                                borrow <= diff[WIDTH];
                                zero   <= (diff[WIDTH-1:0] == '0);
                            end
                            OP_XOR: begin
                                d_out <= d_in0 ^ d_in1;
                                zero  <= ((d_in0 ^ d_in1) == '0);
                            end
                            OP_MOV: begin
                                d_out <= d_in1;
                                zero  <= (d_in1 == '0);
                            end
                            OP_BR: begin
                                d_out <= d_in1;
                                buc   <= (brMode == BR_UNC);
                                bcf   <= (brMode == BR_CARRY) && carry;
                                bbf   <= (brMode == BR_BORROW) && borrow;
                                if (brMode == BR_TOGGLE) begin
                                    toggle_out <= ~toggle_out;
                                end
                            end
                            OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                                state <= ST_MUL;
`else
                                d_out   <= '0;
                                illegal <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                ST_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                    if (mulDone) begin
                        state <= ST_HOLD;
                        d_out <= mulProduct[WIDTH-1:0];
                        carry <= (mulProduct[2*WIDTH-1:WIDTH] != '0);
                        zero  <= (mulProduct[WIDTH-1:0] == '0);
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_HOLD: begin
                    // branch and illegal pulses live only as long as their result
                    if (out_ready) begin
                        state   <= ST_IDLE;
                        bcf     <= 1'b0;
                        bbf     <= 1'b0;
                        buc     <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu against a behavioural model.
// Expectations follow SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;
    localparam int W  = 8;
    localparam int AW = 4;

    localparam logic [2:0] K_ADD = 3'd0;
    localparam logic [2:0] K_SUB = 3'd1;
    localparam logic [2:0] K_XOR = 3'd2;
    localparam logic [2:0] K_MOV = 3'd3;
    localparam logic [2:0] K_ADC = 3'd4;
    localparam logic [2:0] K_SBC = 3'd5;
    localparam logic [2:0] K_BR  = 3'd6;
    localparam logic [2:0] K_MUL = 3'd7;

`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_BUILT = 1'b1;
`else
    localparam bit MUL_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    opcode = '0;
    logic [AW-1:0] addrs = '0;
    logic [W-1:0]  d_in0 = '0;
    logic [W-1:0]  d_in1 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  d_out;
    logic          carry, borrow, zero, bcf, bbf, buc, toggle_out, illegal;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkOn     = 1'b0;

    logic [W-1:0] expD = '0;
    logic expValid = 0, expReady = 0, expCarry = 0, expBorrow = 0, expZero = 0;
    logic expBcf = 0, expBbf = 0, expBuc = 0, expToggle = 0, expIllegal = 0;

    seq_alu #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .addrs(addrs), .d_in0(d_in0), .d_in1(d_in1),
        .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
        .carry(carry), .borrow(borrow), .zero(zero), .bcf(bcf), .bbf(bbf),
        .buc(buc), .toggle_out(toggle_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle the handshake, flags and pulses must match the model; data only while valid
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("in_ready", W'(in_ready), W'(expReady));
            checkOutput("out_valid", W'(out_valid), W'(expValid));
            if (expValid) checkOutput("d_out", d_out, expD);
            checkOutput("carry", W'(carry), W'(expCarry));
            checkOutput("borrow", W'(borrow), W'(expBorrow));
            checkOutput("zero", W'(zero), W'(expZero));
            checkOutput("bcf", W'(bcf), W'(expBcf));
            checkOutput("bbf", W'(bbf), W'(expBbf));
            checkOutput("buc", W'(buc), W'(expBuc));
            checkOutput("toggle_out", W'(toggle_out), W'(expToggle));
            checkOutput("illegal", W'(illegal), W'(expIllegal));
        end
    end

    task automatic computeModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] mode, output logic [W-1:0] nd, output logic nc,
                                output logic nb, output logic nz, output logic nBcf, output logic nBbf,
                                output logic nBuc, output logic nTog, output logic nIll);
        longint unsigned av = a;
        longint unsigned bv = b;
        longint unsigned modulus = longint'(1) << W;
        longint unsigned r;
        nd = expD; nc = expCarry; nb = expBorrow; nz = expZero; nTog = expToggle;
        nBcf = 0; nBbf = 0; nBuc = 0; nIll = 0;
        case (op)
            K_ADD: begin r = av + bv; nd = W'(r); nc = (r >= modulus); end
            K_ADC: begin r = av + bv + expCarry; nd = W'(r); nc = (r >= modulus); end
            K_SUB: begin nd = W'(av - bv); nb = (av < bv); end
            K_SBC: begin nd = W'(av - bv - expBorrow); nb = (av < bv + expBorrow); end
            K_XOR: nd = a ^ b;
            K_MOV: nd = b;
            K_BR: begin
                nd = b;
                nBuc = (mode == 2'd0);
                nBcf = (mode == 2'd1) && expCarry;
                nBbf = (mode == 2'd2) && expBorrow;
                if (mode == 2'd3) nTog = ~expToggle;
            end
            default: begin
                if (MUL_BUILT) begin
                    r = av * bv; nd = W'(r); nc = ((r >> W) != 0);
                end else begin
                    nd = '0; nIll = 1'b1;
                end
            end
        endcase
        if (op != K_BR && !(op == K_MUL && !MUL_BUILT)) nz = (nd == '0);
    endtask

    task automatic jitterInputs();
        in_valid = 1'($urandom);
        opcode   = 3'($urandom);
        addrs    = AW'($urandom);
        d_in0    = W'($urandom);
        d_in1    = W'($urandom);
    endtask

    // Presents one op and returns #1 after the edge that makes its result visible
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] mode);
        logic [W-1:0] nd;
        logic nc, nb, nz, nBcf, nBbf, nBuc, nTog, nIll;
        int lat;
        @(negedge clk);
        opcode = op; d_in0 = a; d_in1 = b; addrs = {2'($urandom), mode};
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        computeModel(op, a, b, mode, nd, nc, nb, nz, nBcf, nBbf, nBuc, nTog, nIll);
        expReady = 1'b0;
        in_valid = 1'b0;
        lat = (op == K_MUL && MUL_BUILT) ? W + 1 : 1;
        for (int i = 1; i < lat; i++) begin
            jitterInputs();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        expValid = 1'b1; expD = nd; expCarry = nc; expBorrow = nb; expZero = nz;
        expBcf = nBcf; expBbf = nBbf; expBuc = nBuc; expToggle = nTog; expIllegal = nIll;
    endtask

    task automatic holdResult(input int n);
        for (int i = 0; i < n; i++) begin
            jitterInputs();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic releaseResult();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        expValid = 0; expBcf = 0; expBbf = 0; expBuc = 0; expIllegal = 0; expReady = 1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"}, W'(in_ready), '0);
        checkOutput({tag, " out_valid"}, W'(out_valid), '0);
        checkOutput({tag, " d_out"}, d_out, '0);
        checkOutput({tag, " flags"}, W'({carry, borrow, zero}), '0);
        checkOutput({tag, " pulses"}, W'({bcf, bbf, buc, illegal}), '0);
        checkOutput({tag, " toggle_out"}, W'(toggle_out), '0);
    endtask

    task automatic clearModel();
        expD = '0; expValid = 0; expCarry = 0; expBorrow = 0; expZero = 0;
        expBcf = 0; expBbf = 0; expBuc = 0; expToggle = 0; expIllegal = 0;
    endtask

    initial begin
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(negedge clk);
        checkAllZero("reset held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready after release", W'(in_ready), W'(1'b1));
        clearModel();
        expReady = 1'b1;
        checkOn = 1'b1;

        applyStimulus(K_ADD, 8'hF0, 8'h20, 2'd0);
        checkOutput("lit ADD d_out", d_out, 8'h10);
        checkOutput("lit ADD carry", W'(carry), W'(1'b1));
        checkOutput("lit ADD zero", W'(zero), W'(1'b0));
        releaseResult();
        applyStimulus(K_ADC, 8'h01, 8'h01, 2'd0);
        checkOutput("lit ADC d_out", d_out, 8'h03);
        checkOutput("lit ADC carry", W'(carry), W'(1'b0));
        releaseResult();

        applyStimulus(K_SUB, 8'h05, 8'h06, 2'd0);
        checkOutput("lit SUB d_out", d_out, 8'hFF);
        checkOutput("lit SUB borrow", W'(borrow), W'(1'b1));
        releaseResult();
        applyStimulus(K_SBC, 8'h10, 8'h0F, 2'd0);
        checkOutput("lit SBC d_out", d_out, 8'h00);
        checkOutput("lit SBC borrow/zero", W'({borrow, zero}), W'(2'b01));
        releaseResult();

        applyStimulus(K_ADD, 8'hFF, 8'h01, 2'd0);
        releaseResult();
        applyStimulus(K_BR, 8'h00, 8'h3C, 2'd1);
        checkOutput("lit BR carry bcf", W'(bcf), W'(1'b1));
        checkOutput("lit BR d_out", d_out, 8'h3C);
        holdResult(3);
        releaseResult();
        applyStimulus(K_BR, 8'h00, 8'h11, 2'd2);
        checkOutput("lit BR borrow bbf", W'(bbf), W'(1'b0));
        releaseResult();
        applyStimulus(K_BR, 8'h00, 8'h22, 2'd3);
        checkOutput("lit toggle first", W'(toggle_out), W'(1'b1));
        releaseResult();
        applyStimulus(K_BR, 8'h00, 8'h33, 2'd3);
        checkOutput("lit toggle second", W'(toggle_out), W'(1'b0));
        releaseResult();

        applyStimulus(K_XOR, 8'hAA, 8'hFF, 2'd0);
        holdResult(5);
        checkOutput("lit XOR held d_out", d_out, 8'h55);
        releaseResult();
        checkOutput("lit in_ready after accept", W'(in_ready), W'(1'b1));

        applyStimulus(K_MUL, 8'h10, 8'h11, 2'd0);
        checkOutput("lit MUL d_out", d_out, MUL_BUILT ? 8'h10 : 8'h00);
        checkOutput("lit MUL carry/illegal", W'({carry, illegal}), MUL_BUILT ? W'(2'b10) : W'(2'b11));
        releaseResult();

        applyStimulus(K_SUB, 8'h00, 8'h01, 2'd0);
        releaseResult();
        applyStimulus(K_BR, 8'h00, 8'h01, 2'd3);
        releaseResult();
        checkOn = 1'b0;
        @(negedge clk);
        opcode = K_MUL; d_in0 = 8'h37; d_in1 = 8'h5B; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkAllZero("mid-op reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearModel();
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            checkOutput("no result after abort", W'(out_valid), '0);
        end
        checkOutput("in_ready after abort", W'(in_ready), W'(1'b1));
        expReady = 1'b1;
        checkOn = 1'b1;

        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
            applyStimulus(rop, ra, rb, 2'($urandom));
            holdResult($urandom_range(0, 3));
            releaseResult();
        end

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
